// File: rtl/dcache_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_ctrl
//   Direct-mapped, write-back, write-allocate L1 data cache controller.
//   Lines are 32 bytes (8 x 32-bit words), 2**IDX_W lines in total. A miss
//   freezes the EX/MEM register through mem_stall. If the victim line is
//   dirty it is first written back (WBACK), then the missing block is
//   refilled (ALLOC). On return to IDLE the held request hits.
//
// Ports
//   clk        clock, all state updates on posedge
//   rst        synchronous active-high reset
//   mem_read   load request (held stable while mem_stall=1)
//   mem_write  store request (held stable while mem_stall=1); wins over mem_read
//   addr       byte address: [4:2] word, [4+IDX_W:5] index, [31:5+IDX_W] tag
//   wdata      store data
//   rdata      load data, valid when mem_read=1 and mem_stall=0, else 0
//   mem_stall  1 = access not complete, upstream must hold
//   ext_req    external memory request
//   ext_we     1 = write-back, 0 = refill
//   ext_addr   block address, [4:0]=0
//   ext_wdata  victim block data (write-back)
//   ext_rdata  refill block data, sampled when ext_ack=1
//   ext_ack    one-cycle completion pulse from external memory
// -----------------------------------------------------------------------------
module dcache_ctrl #(
   parameter int IDX_W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         mem_read,
   input  logic         mem_write,
   input  logic [31:0]  addr,
   input  logic [31:0]  wdata,
   output logic [31:0]  rdata,
   output logic         mem_stall,
   output logic         ext_req,
   output logic         ext_we,
   output logic [31:0]  ext_addr,
   output logic [255:0] ext_wdata,
   input  logic [255:0] ext_rdata,
   input  logic         ext_ack
);

   localparam int TAG_W = 27 - IDX_W;
   localparam int LINES = 1 << IDX_W;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WBACK = 2'd1;
   localparam logic [1:0] S_ALLOC = 2'd2;

   logic [1:0]       state;
   logic [1:0]       state_next;

   logic [TAG_W-1:0] tag_mem  [LINES];
   logic [255:0]     data_mem [LINES];
   logic [LINES-1:0] valid;
   logic [LINES-1:0] dirty;

   // Address fields, taken live every cycle; the request is stable while stalled.
   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag;
   logic [2:0]       word;
   logic             unused_addr_bits;

   assign idx              = addr[4+IDX_W:5];
   assign tag              = addr[31:5+IDX_W];
   assign word             = addr[4:2];
   assign unused_addr_bits = ^addr[1:0];

   logic [255:0]     line;
   logic [TAG_W-1:0] line_tag;
   logic             hit;
   logic             active;
   logic             is_write;

   assign line     = data_mem[idx];
   assign line_tag = tag_mem[idx];
   assign hit      = valid[idx] && (line_tag == tag);
   assign active   = mem_read || mem_write;
   assign is_write = mem_write;  // read+write together behaves as a write

   // Stall whenever a transfer is in flight, or on an IDLE miss before the
   // state machine has reacted.
   assign mem_stall = (state != S_IDLE) || (active && !hit);
   assign rdata     = (state == S_IDLE && mem_read && hit) ? line[{word, 5'b0} +: 32] : 32'd0;

   // Next state and Moore external-interface outputs.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a value unassigned and no latch is inferred.
      state_next = state;
      ext_req    = 1'b0;
      ext_we     = 1'b0;
      ext_addr   = 32'd0;
      ext_wdata  = '0;
      case (state)
         S_IDLE: begin
            if (active && !hit)
               state_next = (valid[idx] && dirty[idx]) ? S_WBACK : S_ALLOC;
         end
         S_WBACK: begin
            ext_req   = 1'b1;
            ext_we    = 1'b1;
            ext_addr  = {line_tag, idx, 5'b0};
            ext_wdata = line;
            if (ext_ack)
               state_next = S_ALLOC;
         end
         S_ALLOC: begin
            ext_req  = 1'b1;
            ext_addr = {tag, idx, 5'b0};
            if (ext_ack)
               state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Control state: FSM plus valid/dirty bits, cleared on reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         state <= S_IDLE;
         valid <= '0;
         dirty <= '0;
      end else begin
         state <= state_next;
         if (state == S_IDLE && is_write && hit)
            dirty[idx] <= 1'b1;
         if (state == S_ALLOC && ext_ack) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
         end
      end
   end

   // Tag and data arrays.
   always_ff @(posedge clk) begin
      // NOTE: the arrays have no reset; valid bits guard their contents.
      // Writes are still blocked during reset so an aborted refill cannot
      // deposit a partial line.
      if (!rst) begin
         if (state == S_IDLE && is_write && hit)
            data_mem[idx][{word, 5'b0} +: 32] <= wdata;
         if (state == S_ALLOC && ext_ack) begin
            data_mem[idx] <= ext_rdata;
            tag_mem[idx]  <= tag;
         end
      end
   end

endmodule
